// File: rtl/coremem_pipe.sv
// ---------------------------------------------------------------------------
// coremem_pipe
//
// Pipelined core-to-SRAM data port adapter. Translates the core data
// protocol (req/gnt/rvalid) into synchronous single-port SRAM strobes and
// returns one in-order response per granted request exactly MEM_LATENCY
// cycles after the grant. Up to MAX_OUTSTANDING requests may be granted
// but not yet answered. Word indices at or above MEM_WORDS are answered
// with an error response and never reach the SRAM.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   data_req_i     core request
//   data_gnt_o     request accepted this cycle (combinational)
//   data_we_i      1 = write, 0 = read
//   data_be_i      byte enables
//   data_addr_i    byte address
//   data_wdata_i   write data
//   data_rvalid_o  response valid, one per grant, in order
//   data_rdata_o   read data (zero for writes, errors and idle cycles)
//   data_err_o     out-of-range error, valid with data_rvalid_o
//   CE / WE        SRAM chip enable / write enable
//   mem_addr_o     SRAM word index
//   mem_wdata_o    SRAM write data
//   mem_be_o       SRAM byte write enables
//   mem_rdata_i    SRAM read data, valid MEM_LATENCY cycles after CE
// ---------------------------------------------------------------------------
module coremem_pipe #(
  parameter int  ADDR_WIDTH      = 16,
  parameter int  DATA_WIDTH      = 32,
  parameter int  MEM_WORDS       = 4096,
  parameter int  MEM_LATENCY     = 1,
  parameter int  MAX_OUTSTANDING = 2,
  localparam int BE_WIDTH        = DATA_WIDTH / 8,
  localparam int MEM_AW          = $clog2(MEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic                  data_we_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic                  CE,
  output logic                  WE,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int OFF   = $clog2(BE_WIDTH);
  localparam int IDX_W = ADDR_WIDTH - OFF;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The word index is compared in 32 bits so MEM_WORDS need not be a power
  // of two and may exceed the index range.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return (32'(idx) < 32'(MEM_WORDS));
  endfunction

  logic [IDX_W-1:0]       idx_s;
  logic                   in_range_s;
  logic                   gnt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic [MEM_LATENCY-1:0] vld_r;
  logic [MEM_LATENCY-1:0] we_r;
  logic [MEM_LATENCY-1:0] err_r;
  logic                   rsp_valid_s;
  logic                   rsp_we_s;
  logic                   rsp_err_s;

  assign idx_s      = data_addr_i[ADDR_WIDTH-1:OFF];
  assign in_range_s = idx_in_range(idx_s);

  // Sub-word address bits select nothing: accesses are word-wide with byte
  // enables, so the low bits are deliberately dropped.
  if (OFF > 0) begin : g_low_addr
    logic addr_unused_s;
    assign addr_unused_s = ^data_addr_i[OFF-1:0];
  end

  // The oldest in-flight response sits in the last pipeline stage.
  assign rsp_valid_s = vld_r[MEM_LATENCY-1];
  assign rsp_we_s    = we_r[MEM_LATENCY-1];
  assign rsp_err_s   = err_r[MEM_LATENCY-1];

  // Grant decision: a slot is free when below the limit, or when the
  // response retiring this cycle hands its slot to the new request.
  always_comb begin
    gnt_s = 1'b0;
    if (rst_ni && data_req_i && ((cnt_r < CNT_MAX) || rsp_valid_s)) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  assign data_gnt_o = gnt_s;

  // SRAM strobes: only in-range granted requests touch the macro; all other
  // cycles drive known zeros on every strobe and data field.
  always_comb begin
    CE          = 1'b0;
    WE          = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (gnt_s && in_range_s) begin
      CE          = 1'b1;
      WE          = data_we_i;
      mem_addr_o  = MEM_AW'(idx_s);
      mem_wdata_o = data_wdata_i;
      mem_be_o    = data_be_i;
    end else begin
      CE          = 1'b0;
      WE          = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
    end
  end

  // Response shift register: loaded on grant, advances every cycle with no
  // back-pressure, so each response leaves exactly MEM_LATENCY cycles later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_r <= '0;
      we_r  <= '0;
      err_r <= '0;
    end else begin
      vld_r[0] <= gnt_s;
      we_r[0]  <= gnt_s & data_we_i;
      err_r[0] <= gnt_s & ~in_range_s;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        we_r[i]  <= we_r[i-1];
        err_r[i] <= err_r[i-1];
      end
    end
  end

  // Response data: SRAM read data is passed through only for in-range reads;
  // writes, errors and idle cycles return zero.
  always_comb begin
    data_rvalid_o = rsp_valid_s;
    data_rdata_o  = '0;
    data_err_o    = 1'b0;
    if (rsp_valid_s && rsp_err_s) begin
      data_err_o = 1'b1;
    end else if (rsp_valid_s && !rsp_we_s) begin
      data_rdata_o = mem_rdata_i;
    end else begin
      data_rdata_o = '0;
      data_err_o   = 1'b0;
    end
  end

  // Outstanding counter next state: grant and retire in one cycle cancel.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({gnt_s, rsp_valid_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Outstanding counter register; reset drops every in-flight request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_coremem_pipe.sv
// ---------------------------------------------------------------------------
// tb_coremem_pipe
//
// Four coremem_pipe instances with different latency/outstanding settings,
// each attached to a small SRAM model. Directed stimulus pushes expected
// responses into per-instance queues; an independent monitor pops and
// compares whenever an instance raises data_rvalid_o, and also checks the
// per-cycle invariants (counter bounds, CE only with grant, known strobes).
//   inst 0: MEM_LATENCY=1 MAX_OUTSTANDING=2
//   inst 1: MEM_LATENCY=3 MAX_OUTSTANDING=3
//   inst 2: MEM_LATENCY=3 MAX_OUTSTANDING=1
//   inst 3: MEM_LATENCY=2 MAX_OUTSTANDING=2
// SRAM contents before any write: word 4 = 0xDEADBEEF, word i = 0xC0DE0000|i.
// ---------------------------------------------------------------------------
module tb_coremem_pipe;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int MW  = 4096;
  localparam int MAW = 12;
  localparam int LAT [N] = '{1, 3, 3, 2};
  localparam int MOS [N] = '{2, 3, 1, 2};

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n  [N];
  logic          req    [N];
  logic          we     [N];
  logic [BW-1:0] be     [N];
  logic [AW-1:0] addr   [N];
  logic [DW-1:0] wdata  [N];
  logic          gnt    [N];
  logic          rvalid [N];
  logic [DW-1:0] rdata  [N];
  logic          err    [N];
  logic          ce     [N];
  logic          mwe    [N];
  logic [MAW-1:0] maddr [N];
  logic [DW-1:0] mwdata [N];
  logic [BW-1:0] mbe    [N];
  logic [DW-1:0] mrdata [N];
  logic [3:0]    cnt_mon [N];

  exp_t sbq [N][$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [MAW-1:0] a);
    if (a == 12'd4) return 32'hDEADBEEF;
    else return 32'hC0DE0000 | 32'(a);
  endfunction

  function automatic logic [DW-1:0] be_mask(input logic [BW-1:0] b);
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < BW; k++) m[8*k +: 8] = {8{b[k]}};
    return m;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    // Stored as XOR with the initial pattern so zero-initialised storage
    // reads back the initial contents.
    bit   [DW-1:0] mem_x [MW];
    logic [DW-1:0] rd_p  [4];

    coremem_pipe #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW),
      .MEM_LATENCY(LAT[g]), .MAX_OUTSTANDING(MOS[g])
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n[g]),
      .data_req_i(req[g]), .data_gnt_o(gnt[g]), .data_we_i(we[g]),
      .data_be_i(be[g]), .data_addr_i(addr[g]), .data_wdata_i(wdata[g]),
      .data_rvalid_o(rvalid[g]), .data_rdata_o(rdata[g]), .data_err_o(err[g]),
      .CE(ce[g]), .WE(mwe[g]), .mem_addr_o(maddr[g]), .mem_wdata_o(mwdata[g]),
      .mem_be_o(mbe[g]), .mem_rdata_i(mrdata[g])
    );

    assign cnt_mon[g] = 4'(u_dut.cnt_r);
    assign mrdata[g]  = rd_p[LAT[g]-1];

    // SRAM model: byte-masked writes, read data after LAT cycles, junk when
    // no read was issued so that stray pass-through is visible.
    always @(posedge clk) begin
      if (ce[g] === 1'b1 && mwe[g] === 1'b1) begin
        mem_x[maddr[g]] <= (((mem_x[maddr[g]] ^ init_word(maddr[g])) & ~be_mask(mbe[g]))
                            | (mwdata[g] & be_mask(mbe[g]))) ^ init_word(maddr[g]);
      end
      if (ce[g] === 1'b1 && mwe[g] === 1'b0) rd_p[0] <= mem_x[maddr[g]] ^ init_word(maddr[g]);
      else rd_p[0] <= 32'hBAD00000 | 32'(cyc & 16'hFFFF);
      for (int k = 1; k < 4; k++) rd_p[k] <= rd_p[k-1];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Present a request at posedge+1, hold it until granted (bounded), check
  // the strobes in the grant cycle and queue the expected response.
  task automatic issue(input int g, input logic w, input logic [BW-1:0] b,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] erd, input logic eerr,
                       input logic [MAW-1:0] eidx, output int gc);
    exp_t e;
    bit   got;
    got = 1'b0;
    gc  = -1;
    req[g] = 1'b1; we[g] = w; be[g] = b; addr[g] = a; wdata[g] = wd;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (gnt[g] === 1'b1) begin
        got = 1'b1;
        gc  = cyc;
        if (eerr) begin
          chk("ce_oor", {ce[g], mwe[g]}, 2'b00);
        end else begin
          chk("ce", ce[g], 1'b1);
          chk("we", mwe[g], w);
          chk("mem_addr", maddr[g], eidx);
          chk("mem_be", mbe[g], b);
          if (w) chk("mem_wdata", mwdata[g], wd);
        end
        e.rdata = erd; e.err = eerr; e.cyc = gc + LAT[g];
        sbq[g].push_back(e);
      end
      @(posedge clk); #1;
    end
    if (!got) chk("gnt_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int g, input int n);
    req[g] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: response scoreboard plus per-cycle invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        if (rst_n[g] === 1'b1) begin
          chk("cnt_max", 64'(cnt_mon[g] <= 4'(MOS[g])), 1'b1);
          chk("cnt_underflow", 64'(rvalid[g] === 1'b1 && cnt_mon[g] == 4'd0), 1'b0);
          chk("ce_wo_gnt", 64'(ce[g] === 1'b1 && gnt[g] !== 1'b1), 1'b0);
          chk("strobe_known", 64'($isunknown({ce[g], mwe[g], maddr[g], mbe[g], mwdata[g]})), 1'b0);
          if (rvalid[g] === 1'b1) begin
            if (sbq[g].size() == 0) begin
              chk("unexpected_rvalid", 1'b1, 1'b0);
            end else begin
              e = sbq[g].pop_front();
              chk("rdata", rdata[g], e.rdata);
              chk("err", err[g], e.err);
              chk("latency", 64'(cyc), 64'(e.cyc));
            end
          end else begin
            chk("idle_resp", {rdata[g], err[g]}, '0);
          end
        end
      end
    end
  end

  initial begin
    int gc;
    int prev;
    int t0;
    for (int g = 0; g < N; g++) begin
      rst_n[g] = 1'b0; req[g] = 1'b0; we[g] = 1'b0;
      be[g] = '0; addr[g] = '0; wdata[g] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < N; g++) req[g] = 1'b1;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("rst_gnt", gnt[g], 1'b0);
      chk("rst_rvalid", rvalid[g], 1'b0);
      chk("rst_resp", {rdata[g], err[g]}, '0);
      chk("rst_ce_we", {ce[g], mwe[g]}, 2'b00);
      chk("rst_cnt", cnt_mon[g], 4'd0);
      req[g] = 1'b0;
    end
    for (int g = 0; g < N; g++) rst_n[g] = 1'b1;
    @(posedge clk); #1;

    // Single read, write, readback with byte merge, ignored low address bits.
    issue(0, 1'b0, 4'hF, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 12'd4, gc);
    idle(0, 2);
    issue(0, 1'b1, 4'b0011, 16'h0008, 32'h1234ABCD, 32'h0, 1'b0, 12'd2, gc);
    issue(0, 1'b0, 4'hF, 16'h0008, 32'h0, 32'hC0DEABCD, 1'b0, 12'd2, gc);
    issue(0, 1'b0, 4'hF, 16'h0013, 32'h0, 32'hDEADBEEF, 1'b0, 12'd4, gc);
    idle(0, 2);

    // Out-of-range read and write, then a normal read.
    issue(0, 1'b0, 4'hF, 16'h4000, 32'h0, 32'h0, 1'b1, 12'd0, gc);
    issue(0, 1'b0, 4'hF, 16'h000C, 32'h0, 32'hC0DE0003, 1'b0, 12'd3, gc);
    issue(0, 1'b1, 4'hF, 16'hFFFC, 32'h55AA55AA, 32'h0, 1'b1, 12'd0, gc);
    issue(0, 1'b0, 4'hF, 16'h0000, 32'h0, 32'hC0DE0000, 1'b0, 12'd0, gc);
    idle(0, 3);

    // Latency 3, three outstanding: eight back-to-back reads.
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      issue(1, 1'b0, 4'hF, 16'(16'h0020 + 4*i), 32'h0, 32'hC0DE0008 + 32'(i), 1'b0,
            12'(8 + i), gc);
      if (i > 0) chk("b2b_gnt", 64'(gc), 64'(prev + 1));
      prev = gc;
    end
    idle(1, 5);

    // Latency 3, one outstanding: grants spaced by the latency.
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      issue(2, 1'b0, 4'hF, 16'(16'h0040 + 4*i), 32'h0, 32'hC0DE0010 + 32'(i), 1'b0,
            12'(16 + i), gc);
      if (i > 0) chk("stall_gnt", 64'(gc), 64'(prev + 3));
      prev = gc;
    end
    idle(2, 5);

    // Latency 2: reset with two requests in flight drops both responses.
    issue(3, 1'b0, 4'hF, 16'h0100, 32'h0, 32'hC0DE0040, 1'b0, 12'd64, gc);
    issue(3, 1'b0, 4'hF, 16'h0104, 32'h0, 32'hC0DE0041, 1'b0, 12'd65, gc);
    req[3]   = 1'b0;
    rst_n[3] = 1'b0;
    sbq[3].delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_drop_rvalid", rvalid[3], 1'b0);
      chk("rst_drop_cnt", cnt_mon[3], 4'd0);
    end
    rst_n[3] = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    issue(3, 1'b0, 4'hF, 16'h0108, 32'h0, 32'hC0DE0042, 1'b0, 12'd66, gc);
    chk("first_gnt_after_rst", 64'(gc), 64'(t0));
    idle(3, 8);

    for (int g = 0; g < N; g++) chk("queue_empty", 64'(sbq[g].size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coremem_pipe.md
Name: coremem_pipe

Overview:
- Parametrised, pipelined successor to the single-outstanding core-to-SRAM data port adapter.
- Converts the core data protocol (req/gnt/rvalid) into synchronous SRAM strobes (CE/WE/addr/wdata/be).
- Responses return in order at a fixed, configurable memory latency, with a bounded number of requests outstanding.
- Adds byte enables, read data return and out-of-range error detection. Sits between the core LSU and a single-port on-chip SRAM macro.

Parameters:
ADDR_WIDTH, 16, byte address width of data_addr_i
DATA_WIDTH, 32, data bus width; multiple of 8, power of two
MEM_WORDS, 4096, SRAM depth in words; word index >= MEM_WORDS is out of range
MEM_LATENCY, 1, cycles from CE cycle to mem_rdata_i valid; legal 1..4
MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; legal 1..8

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
data_req_i  in  1  core request
data_gnt_o  out  1  request accepted this cycle
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  DATA_WIDTH/8  byte enables
data_addr_i  in  ADDR_WIDTH  byte address
data_wdata_i  in  DATA_WIDTH  write data
data_rvalid_o  out  1  response valid; one per granted request, in order
data_rdata_o  out  DATA_WIDTH  read data, valid with data_rvalid_o
data_err_o  out  1  error response, valid with data_rvalid_o
CE  out  1  SRAM chip enable
WE  out  1  SRAM write enable
mem_addr_o  out  clog2(MEM_WORDS)  SRAM word index
mem_wdata_o  out  DATA_WIDTH  SRAM write data
mem_be_o  out  DATA_WIDTH/8  SRAM byte write enables
mem_rdata_i  in  DATA_WIDTH  SRAM read data

Behaviour:
- OFF = clog2(DATA_WIDTH/8). Word index = data_addr_i[ADDR_WIDTH-1:OFF]. Low OFF address bits are ignored. In range iff index < MEM_WORDS.
- Outstanding counter cnt, width clog2(MAX_OUTSTANDING+1):
  - +1 on grant, -1 on data_rvalid_o.
  - Both in the same cycle: unchanged.
- Grant (combinational): data_gnt_o = data_req_i && (cnt < MAX_OUTSTANDING || data_rvalid_o). A retiring response frees its slot in the same cycle.
- SRAM strobes in the grant cycle T (combinational from the inputs):
  - In range: CE=1, WE=data_we_i, mem_addr_o=index, mem_wdata_o=data_wdata_i, mem_be_o=data_be_i.
  - Out of range: CE=0, WE=0. SRAM is untouched.
  - No grant: CE=0, WE=0. mem_addr_o, mem_wdata_o and mem_be_o are don't-care but must not be X.
- Response pipeline: MEM_LATENCY-stage shift register of {valid, we, err}, loaded at T, advancing every cycle.
  - Stage output appears in cycle T+MEM_LATENCY and drives data_rvalid_o there.
  - Response latency is always exactly MEM_LATENCY cycles after grant. No stalls, no rready.
- Response data:
  - Read in range: data_rdata_o = mem_rdata_i in the response cycle (combinational path), data_err_o=0.
  - Write in range: data_rdata_o = 0, data_err_o=0.
  - Out of range (read or write): data_rdata_o = 0, data_err_o=1.
  - No response: data_rdata_o = 0, data_err_o=0.
- Throughput:
  - MAX_OUTSTANDING >= MEM_LATENCY: one grant per cycle, sustained.
  - MAX_OUTSTANDING < MEM_LATENCY: grants stall once cnt = MAX_OUTSTANDING until a response retires.
- Ungranted requests: the core holds req/addr/we/be/wdata stable. The block does not register ungranted requests.
- Reset (asynchronous, any time):
  - Pipeline valids and cnt clear to 0. All in-flight responses are dropped.
  - Reset values: data_gnt_o=0 (reset forces no grant), data_rvalid_o=0, data_err_o=0, data_rdata_o=0, CE=0, WE=0.
  - First grant is possible in the first cycle after deassertion.
- Assertions for the bench:
  - cnt never exceeds MAX_OUTSTANDING.
  - cnt never underflows.
  - CE=0 whenever data_gnt_o=0.
  - Total rvalids equal total grants minus those dropped by reset.

Test Plan:
1. MEM_LATENCY=1, MAX_OUTSTANDING=2: single read at addr 0x10, SRAM returns 0xDEADBEEF -> gnt, CE=1 WE=0 mem_addr_o=4 in cycle T; rvalid with rdata 0xDEADBEEF, err=0 at T+1.
2. Write addr 0x8, be=4'b0011, wdata 0x1234ABCD -> CE=1 WE=1 mem_be_o=0011 mem_addr_o=2 at T; rvalid, rdata=0, err=0 at T+1.
3. MEM_LATENCY=3, MAX_OUTSTANDING=3: req held high for 8 back-to-back reads -> 8 consecutive grants; rvalid on 8 consecutive cycles starting 3 after the first grant, data in order.
4. MEM_LATENCY=3, MAX_OUTSTANDING=1: 3 reads requested -> grants at T, T+3, T+6; each response coincides with the next grant; cnt never exceeds 1.
5. MEM_WORDS=4096: read at byte addr 0x4000 (index 4096) -> gnt=1, CE=0, rvalid with err=1 and rdata=0 after MEM_LATENCY; the following in-range request completes normally.
6. MEM_LATENCY=2: assert rst_ni low one cycle after two grants -> no rvalid ever for either; cnt=0; a new read after reset completes with normal latency.
